// File: rtl/vgg_acc_pkg.sv
// Shared widths and state encoding for the 16-bit serial to 1024-bit parallel loader.
package vgg_acc_pkg;

    localparam int DATA_W = 16;
    localparam int BUS_W  = 1024;
    localparam int ADDR_W = 15;

    typedef enum logic [1:0] {
        S2P_IDLE  = 2'd0,
        S2P_FETCH = 2'd1,
        S2P_DRAIN = 2'd2,
        S2P_HOLD  = 2'd3
    } s2p_state_t;

endpackage

// File: rtl/s2p_credit_cnt.sv
// Counts reads accepted by the bus but not yet returned; can_issue stays high
// while there is room for another read in flight.
module s2p_credit_cnt #(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    input  logic dec,
    output logic can_issue
);

    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !dec) begin
            cnt_d = cnt_q + CW'(1);
        end else if (dec && !inc && (cnt_q != '0)) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign can_issue = (cnt_q < CW'(MAX_OUTSTANDING));

endmodule

// File: rtl/s16_to_p1024.sv
// Gathers NUM_WORDS 16-bit Avalon-MM reads into one 1024-bit word for the PE.
// Optional S2P_ZERO_PAD_EN adds pad_control: a start with pad set yields an all-zero word without bus traffic.
//
//   state | meaning
//   IDLE  | waiting for start_control; outputs quiet
//   FETCH | issuing reads, collecting responses
//   DRAIN | all reads issued, waiting for the remaining responses
//   HOLD  | word complete, data_valid_pe high until PE accepts
module s16_to_p1024
    import vgg_acc_pkg::*;
#(
    parameter int NUM_WORDS       = 64,
    parameter int ADDR_STEP       = 2,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_control,
    input  logic [ADDR_W-1:0] addr_in_control,
`ifdef S2P_ZERO_PAD_EN
    input  logic              pad_control,
`endif
    output logic              busy,
    output logic [BUS_W-1:0]  dataout_pe,
    output logic              data_valid_pe,
    input  logic              data_ready_pe,
    output logic [ADDR_W-1:0] address_input,
    output logic              read_input,
    output logic              chipselect_input,
    output logic [1:0]        byteenable_input,
    input  logic [DATA_W-1:0] readdata_input,
    input  logic              waitrequest_input,
    input  logic              readdatavalid_input
);

    localparam int CNT_W = $clog2(NUM_WORDS + 1);

    s2p_state_t        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  issued_q, issued_d;
    logic [CNT_W-1:0]  returned_q, returned_d;
    logic [BUS_W-1:0]  dout_q, dout_d;

    logic can_issue;
    logic rd_req;
    logic accept;
    logic resp_ok;
    logic start_load;
    logic pad_req;

`ifdef S2P_ZERO_PAD_EN
    assign pad_req = pad_control;
`else
    assign pad_req = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S2P_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S2P_IDLE: begin
                if (start_control) begin
                    state_d = pad_req ? S2P_HOLD : S2P_FETCH;
                end
            end
            S2P_FETCH: begin
                if (issued_q == CNT_W'(NUM_WORDS)) begin
                    state_d = S2P_DRAIN;
                end
            end
            S2P_DRAIN: begin
                if (returned_q == CNT_W'(NUM_WORDS)) begin
                    state_d = S2P_HOLD;
                end
            end
            S2P_HOLD: begin
                if (data_ready_pe) begin
                    state_d = S2P_IDLE;
                end
            end
            default: state_d = S2P_IDLE;
        endcase
    end

    always_comb begin
        busy          = (state_q != S2P_IDLE);
        data_valid_pe = (state_q == S2P_HOLD);
        rd_req        = (state_q == S2P_FETCH) && (issued_q < CNT_W'(NUM_WORDS)) && can_issue;
    end

    // Responses count only while a word is being gathered; strays in IDLE/HOLD are dropped.
    assign accept     = rd_req && !waitrequest_input;
    assign resp_ok    = readdatavalid_input && (returned_q < CNT_W'(NUM_WORDS)) &&
                        ((state_q == S2P_FETCH) || (state_q == S2P_DRAIN));
    assign start_load = (state_q == S2P_IDLE) && start_control;

    always_comb begin
        addr_d     = addr_q;
        issued_d   = issued_q;
        returned_d = returned_q;
        dout_d     = dout_q;
        if (start_load) begin
            addr_d     = addr_in_control;
            issued_d   = '0;
            returned_d = '0;
            dout_d     = '0;
        end else begin
            if (accept) begin
                addr_d   = addr_q + ADDR_W'(ADDR_STEP);
                issued_d = issued_q + CNT_W'(1);
            end
            if (resp_ok) begin
                for (int k = 0; k < NUM_WORDS; k++) begin
                    if (returned_q == CNT_W'(k)) begin
                        dout_d[k*DATA_W +: DATA_W] = readdata_input;
                    end
                end
                returned_d = returned_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q     <= '0;
            issued_q   <= '0;
            returned_q <= '0;
            dout_q     <= '0;
        end else begin
            addr_q     <= addr_d;
            issued_q   <= issued_d;
            returned_q <= returned_d;
            dout_q     <= dout_d;
        end
    end

    s2p_credit_cnt #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) u_credit (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (start_load),
        .inc       (accept),
        .dec       (resp_ok),
        .can_issue (can_issue)
    );

    assign dataout_pe       = dout_q;
    assign address_input    = addr_q;
    assign read_input       = rd_req;
    assign chipselect_input = rd_req;
    assign byteenable_input = 2'b11;

endmodule

// File: doc/s16_to_p1024.md
S16_TO_P1024 -- requirements
Module: s16_to_p1024

Interface
REQ-001 Parameter NUM_WORDS, 64, number of 16-bit reads packed per 1024-bit word.
REQ-002 Parameter ADDR_STEP, 2, byte-address increment per read.
REQ-003 Parameter MAX_OUTSTANDING, 4, maximum accepted-but-unreturned reads.
REQ-004 clk  in  1  clock; reset rst_n, synchronous, active-low.
REQ-005 rst_n  in  1  synchronous active-low reset.
REQ-006 start_control  in  1  one-cycle request to load a word; sampled only in IDLE.
REQ-007 addr_in_control  in  15  base byte address of the word, sampled with start_control.
REQ-008 busy  out  1  high in any state other than IDLE.
REQ-009 dataout_pe  out  1024  packed word to PE; read k occupies bits [16k+15:16k].
REQ-010 data_valid_pe  out  1  dataout_pe complete and stable.
REQ-011 data_ready_pe  in  1  PE accepts dataout_pe when high together with data_valid_pe.
REQ-012 address_input  out  15  Avalon-MM read address.
REQ-013 read_input, chipselect_input  out  1 each  Avalon read strobe and select.
REQ-014 byteenable_input  out  2  constant 2'b11.
REQ-015 readdata_input  in  16; waitrequest_input  in  1; readdatavalid_input  in  1  Avalon read-response signals.

Function
REQ-016 States: IDLE, FETCH, DRAIN, HOLD; transitions occur only on the rising edge of clk.
REQ-017 IDLE: start_control=1 -> latch base address, clear issue/return counters and dataout_pe, go to FETCH.
REQ-018 FETCH: read_input=chipselect_input=1 when issued<NUM_WORDS and outstanding<MAX_OUTSTANDING; otherwise both 0.
REQ-019 A read is accepted in a cycle where read_input=1 and waitrequest_input=0; on acceptance, address advances by ADDR_STEP and issued increments.
REQ-020 While waitrequest_input=1, address_input and read_input hold unchanged.
REQ-021 outstanding = accepted reads minus returned reads; simultaneous accept and return leave it unchanged.
REQ-022 On each readdatavalid_input=1, readdata_input is written to slot returned, and returned increments; the response is never dropped, including in the accept cycle.
REQ-023 issued=NUM_WORDS -> DRAIN; read_input=0 in DRAIN.
REQ-024 returned=NUM_WORDS -> HOLD with data_valid_pe=1 in the next cycle; minimum start-to-valid latency is NUM_WORDS+read latency+1 cycles.
REQ-025 HOLD: data_valid_pe stays 1 and dataout_pe is stable until data_ready_pe=1, then IDLE with data_valid_pe=0 in the next cycle.
REQ-026 start_control outside IDLE is ignored.
REQ-027 readdatavalid_input in IDLE or HOLD is ignored.
REQ-028 Address arithmetic wraps modulo 2^15 with no error.
REQ-029 busy=0 only in IDLE.

Reset
REQ-030 rst_n=0 at a clock edge -> state IDLE, counters 0, dataout_pe all zero, data_valid_pe=0, read_input=0, chipselect_input=0, address_input=0.
REQ-031 Reset mid-FETCH/DRAIN abandons the word; late readdatavalid_input after reset is ignored.

Configuration
REQ-032 Macro S2P_ZERO_PAD_EN defined -> input port pad_control (1 bit) exists; pad_control=1 with start_control in IDLE -> HOLD next cycle with dataout_pe all zero, no bus reads.
REQ-033 Macro undefined -> no pad_control port, and every start performs NUM_WORDS reads.

Structure
REQ-034 Package vgg_acc_pkg holds DATA_W=16, BUS_W=1024, ADDR_W=15 and the s2p_state_t enum.
REQ-035 One sub-module, s2p_credit_cnt, tracks outstanding reads and provides the can_issue output.

Verification
REQ-036 Zero-wait slave, latency 1: start, base 0x0100, memory[i]=i -> 64 reads at 0x0100..0x017E; dataout_pe[16k+15:16k]=k; data_valid_pe on cycle 66.
REQ-037 waitrequest_input=1 for 3 cycles on every 8th read -> address held during stalls; final word identical to REQ-036.
REQ-038 Latency 6 slave -> outstanding never exceeds 4; word correct.
REQ-039 data_ready_pe=0 for 10 cycles in HOLD; start_control pulsed meanwhile -> word stable, start ignored, IDLE one cycle after ready.
REQ-040 rst_n=0 after 20 reads; late readdatavalid_input follows -> all outputs at reset values; next start, base 0x7FFC -> addresses wrap to 0x0000.
REQ-041 S2P_ZERO_PAD_EN defined, pad_control=1 -> no read_input pulses; data_valid_pe=1 with 1024'b0 one cycle after start.
